// File: rtl/fifo_fault_ctrl.sv
// FIFO fault controller: debounces monitor errors, flushes the FIFO,
// retries a bounded number of times and locks out on persistent faults.
module fifo_fault_ctrl #(
  parameter int DEBOUNCE     = 2,
  parameter int FLUSH_CYCLES = 4,
  parameter int MAX_RETRY    = 3,
  parameter int CLEAN_CYCLES = 16,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 DetectedError,
  input  logic                 WriteReq,
  input  logic                 ReadReq,
  input  logic                 ClearLock,
  output logic                 WriteEn,
  output logic                 ReadEn,
  output logic                 FifoReset_,
  output logic [2:0]           State,
  output logic                 Alarm,
  output logic                 Locked,
  output logic [3:0]           RetryCount,
  output logic [CNT_WIDTH-1:0] FaultCount
);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_CONFIRM = 3'd1,
    S_HOLD    = 3'd2,
    S_FLUSH   = 3'd3,
    S_RECOVER = 3'd4,
    S_LOCKED  = 3'd5
  } state_e;

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int CW = $clog2(CLEAN_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE);
  localparam logic [FW-1:0] FL_LAST   = FW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] CL_LAST   = CW'(CLEAN_CYCLES);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  state_e               state_q, state_d;
  logic [DW-1:0]        dbc_q, dbc_d;
  logic [FW-1:0]        flush_q, flush_d;
  logic [CW-1:0]        clean_q, clean_d;
  logic                 rec_q, rec_d;
  logic [3:0]           retry_q, retry_d;
  logic [CNT_WIDTH-1:0] fault_q, fault_d;
  logic                 alarm_q, alarm_d;

  assign State      = state_q;
  assign Alarm      = alarm_q;
  assign Locked     = (state_q == S_LOCKED);
  assign RetryCount = retry_q;
  assign FaultCount = fault_q;
  assign WriteEn    = WriteReq & ~Reset & (state_q == S_RUN);
  assign ReadEn     = ReadReq & ~Reset & (state_q == S_RUN);
  assign FifoReset_ = ~(Reset | (state_q == S_FLUSH) |
                        (state_q == S_LOCKED));

  always_comb begin
    state_d = state_q;
    dbc_d   = '0;
    flush_d = '0;
    clean_d = '0;
    rec_d   = 1'b0;
    retry_d = retry_q;
    fault_d = fault_q;
    alarm_d = alarm_q & ~ClearLock;

    // A long enough error-free run forgives earlier recoveries.
    if (state_q == S_RUN && !DetectedError) begin
      clean_d = clean_q + CW'(1);
      if (clean_d == CL_LAST) begin
        clean_d = '0;
        retry_d = '0;
      end
    end

    case (state_q)
      S_RUN: begin
        if (DetectedError) begin
          dbc_d   = DW'(1);
          state_d = S_CONFIRM;
        end
      end
      S_CONFIRM: begin
        if (DetectedError) begin
          dbc_d = dbc_q + DW'(1);
          if (dbc_d == DB_LAST) state_d = S_HOLD;
        end else begin
          state_d = S_RUN;
        end
      end
      S_HOLD: begin
        if (fault_q != '1) fault_d = fault_q + CNT_WIDTH'(1);
        alarm_d = 1'b1;
        if (retry_q == RETRY_MAX) begin
          state_d = S_LOCKED;
        end else begin
          retry_d = retry_q + 4'd1;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (flush_q == FL_LAST) state_d = S_RECOVER;
        else flush_d = flush_q + FW'(1);
      end
      S_RECOVER: begin
        // First cycle lets the monitor settle after its reset.
        if (!rec_q) rec_d = 1'b1;
        else state_d = DetectedError ? S_HOLD : S_RUN;
      end
      S_LOCKED: begin
        if (ClearLock) begin
          state_d = S_RECOVER;
          retry_d = '0;
        end
      end
      default: state_d = S_LOCKED;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_RUN;
      dbc_q   <= '0;
      flush_q <= '0;
      clean_q <= '0;
      rec_q   <= 1'b0;
      retry_q <= '0;
      fault_q <= '0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dbc_q   <= dbc_d;
      flush_q <= flush_d;
      clean_q <= clean_d;
      rec_q   <= rec_d;
      retry_q <= retry_d;
      fault_q <= fault_d;
      alarm_q <= alarm_d;
    end
  end

endmodule
